// File: rtl/anita_scaler_bank.sv
// Trigger-rate scaler bank: per-channel saturating counters, snapshotted and cleared on PPS,
// read back through one addressed port with one-cycle latency.
module anita_scaler_bank #(
    parameter int unsigned NCHAN      = 16,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE   = 0,
    parameter int unsigned ADDR_BITS  = 4,
    parameter int unsigned EPOCH_BITS = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pps_i,
    input  logic [NCHAN-1:0]      count_i,
    input  logic [NCHAN-1:0]      mask_i,
    input  logic                  edge_mode_i,
    input  logic                  rd_i,
    input  logic [ADDR_BITS-1:0]  rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  rd_sat_o,
    output logic                  rd_valid_o,
    output logic                  latch_o,
    output logic [EPOCH_BITS-1:0] epoch_o
);

    localparam int unsigned CW = WIDTH + PRESCALE;

    logic [CW-1:0]    cnt_q     [NCHAN];
    logic [CW:0]      cnt_sum   [NCHAN];
    logic [WIDTH-1:0] latched_q [NCHAN];
    logic [NCHAN-1:0] sat_q;
    logic [NCHAN-1:0] count_q;
    logic [NCHAN-1:0] inc;
    logic [NCHAN-1:0] full;
    logic [WIDTH-1:0] rd_data_d;
    logic             rd_sat_d;

    // Carry out of counter+1 marks an all-ones (saturated) counter.
    always_comb begin
        for (int c = 0; c < int'(NCHAN); c++) begin
            cnt_sum[c] = {1'b0, cnt_q[c]} + {{CW{1'b0}}, 1'b1};
            full[c]    = cnt_sum[c][CW];
            inc[c]     = count_i[c] & ~(edge_mode_i & count_q[c]) & ~mask_i[c];
        end
    end

    always_comb begin
        rd_data_d = '0;
        rd_sat_d  = 1'b0;
        for (int c = 0; c < int'(NCHAN); c++) begin
            if (rd_addr_i == ADDR_BITS'(c)) begin
                rd_data_d = latched_q[c];
                rd_sat_d  = sat_q[c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < int'(NCHAN); c++) begin
                cnt_q[c]     <= '0;
                latched_q[c] <= '0;
            end
            sat_q      <= '0;
            // All-ones so an input already high at release is not seen as an edge.
            count_q    <= '1;
            rd_data_o  <= '0;
            rd_sat_o   <= 1'b0;
            rd_valid_o <= 1'b0;
            latch_o    <= 1'b0;
            epoch_o    <= '0;
        end else begin
            count_q    <= count_i;
            latch_o    <= pps_i;
            rd_valid_o <= rd_i;
            if (rd_i) begin
                rd_data_o <= rd_data_d;
                rd_sat_o  <= rd_sat_d;
            end
            if (pps_i) begin
                epoch_o <= epoch_o + {{(EPOCH_BITS-1){1'b0}}, 1'b1};
            end
            for (int c = 0; c < int'(NCHAN); c++) begin
                if (pps_i) begin
                    latched_q[c] <= cnt_q[c][PRESCALE +: WIDTH];
                    sat_q[c]     <= full[c];
                    cnt_q[c]     <= '0;
                end else if (inc[c] && !full[c]) begin
                    cnt_q[c] <= cnt_sum[c][CW-1:0];
                end
            end
        end
    end

endmodule
